instr_fetch: RTL and testbench

- Fetch stage directly downstream of Program_Counter.
- Takes current_pc and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs and presents them to decode over valid/ready.
- Tells the PC register when to advance (pc_advance, pc_plus4); kills in-flight work on a redirect flush.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 44 ++++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;
  typedef enum logic [1:0] {FETCH, STALL, HALT} fetch_state_t;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [INSTR_W-1:0] instr;
    logic fault;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear; push into a full FIFO succeeds only alongside a pop
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  T din,
  output T dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  // pointer/count update; clear wins over push and pop
  always_ff @(posedge clk)
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= nxt(wp);
      end
      if (do_pop) rp <= nxt(rp);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage issuing imem requests for current_pc and buffering results for decode; FETCH_PERF_CNT_EN adds perf counters
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int n = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int IBUF_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic [n-1:0] current_pc,
  output logic pc_advance,
  output logic [n-1:0] pc_plus4,
  input  logic flush,
  output logic imem_req_valid,
  input  logic imem_req_ready,
  output logic [n-1:0] imem_req_addr,
  input  logic imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic imem_rsp_err,
  output logic if_valid,
  input  logic if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [n-1:0] if_pc,
  output logic if_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`endif
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(IBUF_DEPTH + 1);
  fetch_state_t state, state_nxt;
  logic [OW-1:0] outstanding, kill;
  logic [BW-1:0] buffered;
  logic [n-1:0] rsp_pc;
  logic credit, misaligned, issue, fault_push, rsp_push, req_fire, ib_pop;
  logic pq_full, pq_empty, ib_full, ib_empty;
  fetch_entry_t ib_din, ib_dout;
  assign pc_plus4 = current_pc + n'(4);
  assign misaligned = current_pc[1:0] != 2'b00;
  assign credit = (int'(outstanding) - int'(kill) + int'(buffered) < IBUF_DEPTH) &&
                  (int'(outstanding) < MAX_OUTSTANDING);
  assign rsp_push = imem_rsp_valid && kill == '0 && !flush;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign imem_req_addr = reset ? '0 : current_pc;
  assign ib_pop = if_valid && if_ready;
  assign ib_din = fault_push ?
    '{pc: XLEN'(current_pc), instr: NOP_INSTR, fault: 1'b1} :
    '{pc: XLEN'(rsp_pc), instr: imem_rsp_err ? NOP_INSTR : imem_rsp_data, fault: imem_rsp_err};
  assign if_valid = !ib_empty;
  assign if_instr = if_valid ? ib_dout.instr : '0;
  assign if_pc = if_valid ? n'(ib_dout.pc) : '0;
  assign if_fault = if_valid && ib_dout.fault;
  // issue decisions and next state; a fault entry waits until no live fetch is ahead of it
  always_comb begin
    issue = !reset && !flush && state == FETCH && credit;
    imem_req_valid = issue && !misaligned;
    fault_push = issue && misaligned && outstanding == kill;
    pc_advance = (imem_req_valid && imem_req_ready) || fault_push;
    state_nxt = flush ? FETCH :
                (rsp_push && imem_rsp_err) || fault_push || state == HALT ? HALT :
                credit ? FETCH : STALL;
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= FETCH;
    else state <= state_nxt;
  // responses still owed to requests issued before the last flush
  always_ff @(posedge clk)
    if (reset) kill <= '0;
    else if (flush) kill <= outstanding - OW'(imem_rsp_valid && !pq_empty);
    else if (imem_rsp_valid && kill != '0) kill <= kill - OW'(1);
  fetch_fifo #(.DEPTH(MAX_OUTSTANDING), .T(logic [n-1:0])) u_pcq (
    .clk(clk), .rst(reset), .clear(1'b0), .push(req_fire), .pop(imem_rsp_valid),
    .din(current_pc), .dout(rsp_pc), .full(pq_full), .empty(pq_empty), .count(outstanding)
  );
  fetch_fifo #(.DEPTH(IBUF_DEPTH), .T(fetch_entry_t)) u_ibuf (
    .clk(clk), .rst(reset), .clear(flush), .push(rsp_push || fault_push), .pop(ib_pop),
    .din(ib_din), .dout(ib_dout), .full(ib_full), .empty(ib_empty), .count(buffered)
  );
  a_rsp_orphan: assert property (@(posedge clk) disable iff (reset) !(imem_rsp_valid && pq_empty));
  a_pcq_over: assert property (@(posedge clk) disable iff (reset) !(req_fire && pq_full && !imem_rsp_valid));
  a_ibuf_over: assert property (@(posedge clk) disable iff (reset)
    !((rsp_push || fault_push) && ib_full && !ib_pop && !flush));
`ifdef FETCH_PERF_CNT_EN
  // decode handshakes and stalled cycles
  always_ff @(posedge clk)
    if (reset) begin
      perf_fetched <= '0;
      perf_stall <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(ib_pop);
      perf_stall <= perf_stall + 32'(state == STALL || (imem_req_valid && !imem_req_ready));
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against an in-order memory model
module tb_instr_fetch;
  import fetch_pkg::*;
  typedef struct { logic [31:0] pc; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;
  logic clk = 0, reset = 1, flush = 0, imem_req_ready = 1, imem_rsp_valid = 0, imem_rsp_err = 0, if_ready = 1;
  logic [31:0] current_pc = 0, imem_rsp_data = 0, err_pc = 32'h1, base;
  logic pc_advance, imem_req_valid, if_valid, if_fault, adv_s;
  logic [31:0] pc_plus4, imem_req_addr, if_instr, if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif
  int lat = 1, cyc = 0, hs = 0, n_chk = 0, n_fail = 0;
  req_t q[$];
  ent_t got[$];
  instr_fetch dut (
    .clk(clk), .reset(reset), .current_pc(current_pc), .pc_advance(pc_advance), .pc_plus4(pc_plus4),
    .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_fault(if_fault)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    adv_s = pc_advance;
    if (imem_req_valid && imem_req_ready) q.push_back('{imem_req_addr, cyc + lat});
    if (if_valid && if_ready) begin
      got.push_back('{if_pc, if_instr, if_fault});
      hs++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (adv_s) current_pc = current_pc + 32'd4;
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data = 32'hAAAA0000 + q[0].pc;
      imem_rsp_err = q[0].pc == err_pc;
      void'(q.pop_front());
    end else begin
      imem_rsp_valid = 0;
      imem_rsp_err = 0;
    end
  endtask
  task automatic wait_got(input int k, input string tag);
    int i = 0;
    while (got.size() < k && i < 60) begin
      step();
      i++;
    end
    chk(tag, 64'(got.size() >= k), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    step();
    step();
    chk("rst_if_valid", if_valid, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_adv", pc_advance, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_plus4", pc_plus4, 4);
    reset = 0;
    #1;
    chk("t1_req", imem_req_valid, 1);
    chk("t1_addr", imem_req_addr, 0);
    chk("t1_adv", pc_advance, 1);
    step();
    chk("t1_lat_rsp", if_valid, 0);
    step();
    chk("t1_lat_out", if_valid, 1);
    chk("t1_lat_pc", if_pc, 0);
    wait_got(3, "t1_tmo");
    for (int i = 0; i < 3; i++) begin
      chk("t1_pc", got[i].pc, 64'(4 * i));
      chk("t1_instr", got[i].instr, 64'(32'hAAAA0000 + 32'(4 * i)));
      chk("t1_fault", got[i].fault, 0);
    end
    base = got[got.size()-1].pc;
    if_ready = 0;
    repeat (6) step();
    chk("t2_valid", if_valid, 1);
    chk("t2_count", dut.u_ibuf.count, 2);
    chk("t2_req", imem_req_valid, 0);
    chk("t2_state", dut.state, STALL);
    chk("t2_pc", if_pc, base + 4);
    chk("t2_instr", if_instr, 32'hAAAA0000 + base + 4);
    repeat (3) step();
    chk("t2_hold_pc", if_pc, base + 4);
    chk("t2_hold_instr", if_instr, 32'hAAAA0000 + base + 4);
    got.delete();
    if_ready = 1;
    wait_got(3, "t2_tmo");
    for (int i = 0; i < 3; i++) chk("t2_seq", got[i].pc, 64'(base + 32'(4 * (i + 1))));
    flush = 1;
    current_pc = 32'h10;
    lat = 6;
    #1;
    chk("t3_flush_req", imem_req_valid, 0);
    step();
    flush = 0;
    got.delete();
    repeat (3) step();
    chk("t3_outstanding", dut.outstanding, 2);
    chk("t3_req", imem_req_valid, 0);
    chk("t3_none", got.size(), 0);
    flush = 1;
    current_pc = 32'h100;
    #1;
    chk("t3_flush_adv", pc_advance, 0);
    step();
    flush = 0;
    lat = 1;
    chk("t3_kill", dut.kill, 2);
    chk("t3_cleared", if_valid, 0);
    got.delete();
    wait_got(2, "t3_tmo");
    chk("t3_pc0", got[0].pc, 32'h100);
    chk("t3_instr0", got[0].instr, 32'hAAAA0100);
    chk("t3_pc1", got[1].pc, 32'h104);
    flush = 1;
    current_pc = 32'h102;
    step();
    flush = 0;
    got.delete();
    #1;
    chk("t4_req", imem_req_valid, 0);
    chk("t4_adv", pc_advance, 1);
    wait_got(1, "t4_tmo");
    chk("t4_pc", got[0].pc, 32'h102);
    chk("t4_instr", got[0].instr, 32'h00000013);
    chk("t4_fault", got[0].fault, 1);
    repeat (4) step();
    chk("t4_halt", dut.state, HALT);
    chk("t4_halt_req", imem_req_valid, 0);
    chk("t4_one", got.size(), 1);
    flush = 1;
    current_pc = 32'h200;
    step();
    flush = 0;
    got.delete();
    wait_got(1, "t4_tmo2");
    chk("t4_resume_pc", got[0].pc, 32'h200);
    chk("t4_resume_instr", got[0].instr, 32'hAAAA0200);
    chk("t4_resume_fault", got[0].fault, 0);
    err_pc = 32'h40;
    flush = 1;
    current_pc = 32'h40;
    step();
    flush = 0;
    got.delete();
    wait_got(1, "t5_tmo");
    chk("t5_pc", got[0].pc, 32'h40);
    chk("t5_instr", got[0].instr, 32'h00000013);
    chk("t5_fault", got[0].fault, 1);
    repeat (4) step();
    chk("t5_halt", dut.state, HALT);
    chk("t5_req", imem_req_valid, 0);
    reset = 1;
    q.delete();
    imem_rsp_valid = 0;
    step();
    chk("t5_rst_valid", if_valid, 0);
    chk("t5_rst_pc", if_pc, 0);
    chk("t5_rst_instr", if_instr, 0);
    chk("t5_rst_fault", if_fault, 0);
    chk("t5_rst_req", imem_req_valid, 0);
    chk("t5_rst_adv", pc_advance, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("t5_rst_perf_f", perf_fetched, 0);
    chk("t5_rst_perf_s", perf_stall, 0);
`endif
    current_pc = 32'hFFFFFFFC;
    err_pc = 32'h1;
    hs = 0;
    got.delete();
    #1;
    chk("t6_wrap", pc_plus4, 0);
    reset = 0;
    wait_got(2, "t6_tmo");
    chk("t6_pc0", got[0].pc, 32'hFFFFFFFC);
    chk("t6_instr0", got[0].instr, 32'hAAA9FFFC);
    chk("t6_pc1", got[1].pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf", perf_fetched, 64'(hs));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
